seq_signed_divider: RTL and testbench

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

---
 rtl/seq_signed_divider.sv | 193 +++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
//
// Sequential two's-complement divider. It captures the operand magnitudes and
// signs, runs one unsigned restoring-division step per clock (DW steps), then
// applies the signs in a final FIX cycle and holds the results in DONE.
// With DW=8 the result is valid 9 edges after the accepting edge.
//
// Quotient truncates toward zero. Remainder takes the sign of the dividend.
// The most-negative dividend divided by -1 wraps to the most-negative value
// and raises ovf.
//
// Optional feature (compile-time macro DIV_ZERO_DETECT_EN):
//   defined   - a zero divisor skips RUN, goes straight to FIX and reports
//               div_by_zero=1, remainder=0 and a saturated quotient.
//   undefined - div_by_zero is tied 0. A zero divisor runs the full latency
//               and yields a deterministic but meaningless result.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   start       in   request, sampled only in IDLE or DONE
//   dividend    in   [DW-1:0] two's-complement dividend
//   divisor     in   [VW-1:0] two's-complement divisor
//   busy        out  operation in progress (RUN or FIX)
//   valid       out  results held (DONE)
//   quotient    out  [DW-1:0] signed quotient
//   remainder   out  [VW-1:0] signed remainder
//   ovf         out  quotient overflow (most-negative / -1)
//   div_by_zero out  zero-divisor flag
// -----------------------------------------------------------------------------
module seq_signed_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          valid,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          ovf,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] q_q, q_d;       // dividend magnitude shifting out, quotient magnitude shifting in
  logic [VW-1:0] r_q, r_d;       // partial remainder magnitude
  logic [VW-1:0] dmag_q, dmag_d; // divisor magnitude
  logic          qneg_q, qneg_d; // quotient is negative
  logic          rneg_q, rneg_d; // dividend (and so remainder) is negative
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          ovf_q, ovf_d;
`ifdef DIV_ZERO_DETECT_EN
  logic          zero_q, zero_d;
  logic          dbz_q, dbz_d;
`endif

  // Magnitudes are read as unsigned, so -2^(DW-1) and -2^(VW-1) map to
  // exactly 2^(DW-1) and 2^(VW-1) without needing an extra bit.
  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  assign a_mag = dividend[DW-1] ? -dividend : dividend;
  assign b_mag = divisor[VW-1]  ? -divisor  : divisor;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The extra top bit keeps the compare exact.
  logic [VW:0] trial, diff;
  assign trial = {r_q, q_q[DW-1]};
  assign diff  = trial - {1'b0, dmag_q};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dmag_d  = dmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
`ifdef DIV_ZERO_DETECT_EN
    zero_d  = zero_q;
    dbz_d   = dbz_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        // Results stay on the outputs; only valid drops (via the state change).
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          q_d     = a_mag;
          r_d     = '0;
          dmag_d  = b_mag;
          qneg_d  = dividend[DW-1] ^ divisor[VW-1];
          rneg_d  = dividend[DW-1];
`ifdef DIV_ZERO_DETECT_EN
          zero_d  = (divisor == '0);
          if (divisor == '0) state_d = FIX;
`endif
        end
      end
      RUN: begin
        if (trial >= {1'b0, dmag_q}) begin
          r_d = diff[VW-1:0];
          q_d = {q_q[DW-2:0], 1'b1};
        end else begin
          r_d = trial[VW-1:0];
          q_d = {q_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        quo_d   = qneg_q ? -q_q : q_q;
        rem_d   = rneg_q ? -r_q : r_q;
        // A positive quotient with the top magnitude bit set can only come
        // from most-negative / -1; it wraps to the most-negative value.
        ovf_d   = ~qneg_q & q_q[DW-1];
`ifdef DIV_ZERO_DETECT_EN
        dbz_d   = zero_q;
        if (zero_q) begin
          quo_d = rneg_q ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
          rem_d = '0;
          ovf_d = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dmag_q  <= dmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
`ifdef DIV_ZERO_DETECT_EN
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy      = (state_q == RUN) || (state_q == FIX);
  assign valid     = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_divider
//
// Self-checking bench for seq_signed_divider (DW=8, VW=4). Directed table
// vectors, reset and back-to-back sequences, then random operations checked
// against an integer-arithmetic reference model. Honours DIV_ZERO_DETECT_EN.
// -----------------------------------------------------------------------------
module tb_seq_signed_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy, valid, ovf, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int vectors    = 0;
  int miscompares = 0;

  seq_signed_divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int o;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division (truncating, remainder follows the
  // dividend), then wrap the quotient into DW bits.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int o, output int z);
    z = 0;
    if (b == 0) begin
      q = (a >= 0) ? 127 : -128;
      r = 0;
      o = 0;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      o = (q > 127) ? 1 : 0;
      if (q > 127) q -= 256;
    end
  endtask

  function automatic int sq(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sr(input logic [VW-1:0] v);
    return int'($signed(v));
  endfunction

  // Launch one operation and count edges after the accept edge until valid.
  // With noise, start is toggled and operands scrambled while busy.
  task automatic do_op(input int a, input int b, input bit noise, output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    start    = 1'b1;
    dividend = DW'(a);
    divisor  = VW'(b);
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) break;
      if (!busy) busy_ok = 1'b0;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
      end
      @(posedge clk);
      lat++;
    end
    start = 1'b0;
    check("busy_during_op", int'(busy_ok), 1);
  endtask

  task automatic check_res(input string tag, input int a, input int b, input int lat);
    int eq, er, eo, ez;
    model(a, b, eq, er, eo, ez);
`ifdef DIV_ZERO_DETECT_EN
    check({tag, "_lat"}, lat, ez ? 1 : DW + 1);
    check({tag, "_dbz"}, int'(div_by_zero), ez);
`else
    check({tag, "_lat"}, lat, DW + 1);
    check({tag, "_dbz"}, int'(div_by_zero), 0);
`endif
    check({tag, "_valid"}, int'(valid), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_q"}, sq(quotient), eq);
    check({tag, "_r"}, sr(remainder), er);
    check({tag, "_ovf"}, int'(ovf), eo);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_q"}, int'(quotient), 0);
    check({tag, "_r"}, int'(remainder), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_dbz"}, int'(div_by_zero), 0);
  endtask

  initial begin
    vec_t tbl[$];
    int   lat, low, a, b, hold_q;
    bit   saw_valid;

    // Expected values are worked out by hand, independent of the model.
    tbl.push_back('{a:   56, b:  7, q:    8, r:  0, o: 0});
    tbl.push_back('{a:  -28, b:  6, q:   -4, r: -4, o: 0});
    tbl.push_back('{a:  127, b: -8, q:  -15, r:  7, o: 0});
    tbl.push_back('{a: -128, b: -1, q: -128, r:  0, o: 1});
    tbl.push_back('{a: -128, b: -8, q:   16, r:  0, o: 0});
    tbl.push_back('{a:   20, b:  3, q:    6, r:  2, o: 0});
    tbl.push_back('{a: -128, b:  1, q: -128, r:  0, o: 0});
    tbl.push_back('{a:   -1, b:  7, q:    0, r: -1, o: 0});
    tbl.push_back('{a: -127, b:  7, q:  -18, r: -1, o: 0});
    tbl.push_back('{a:  100, b: -3, q:  -33, r:  1, o: 0});
    tbl.push_back('{a:    0, b:  5, q:    0, r:  0, o: 0});

    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst      = 1'b0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Directed table; start is pulsed randomly while busy.
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, 1'b1, lat);
      check($sformatf("tbl%0d_lat", i), lat, DW + 1);
      check($sformatf("tbl%0d_q", i), sq(quotient), tbl[i].q);
      check($sformatf("tbl%0d_r", i), sr(remainder), tbl[i].r);
      check($sformatf("tbl%0d_ovf", i), int'(ovf), tbl[i].o);
    end

    // Results hold in DONE while start stays low.
    hold_q = sq(quotient);
    repeat (3) @(negedge clk);
    check("done_hold_valid", int'(valid), 1);
    check("done_hold_q", sq(quotient), hold_q);

`ifdef DIV_ZERO_DETECT_EN
    do_op(5, 0, 1'b0, lat);
    check_res("dz_pos", 5, 0, lat);
    check("dz_pos_q_direct", sq(quotient), 127);
    do_op(-5, 0, 1'b0, lat);
    check_res("dz_neg", -5, 0, lat);
    check("dz_neg_q_direct", sq(quotient), -128);
`endif

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    start    = 1'b1;
    dividend = DW'(100);
    divisor  = VW'(7);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("midrun_rst");
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (valid) saw_valid = 1'b1;
    end
    check("midrun_no_valid", int'(saw_valid), 0);
    do_op(20, 3, 1'b0, lat);
    check_res("post_rst", 20, 3, lat);

    // Back-to-back with start held high from DONE.
    @(negedge clk);
    start    = 1'b1;
    dividend = DW'(-90);
    divisor  = VW'(7);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) break;
      low++;
    end
    check("b2b1_low", low, DW + 1);
    check("b2b1_q", sq(quotient), -12);
    check("b2b1_r", sr(remainder), -6);
    dividend = DW'(77);
    divisor  = VW'(-5);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) break;
      low++;
    end
    start = 1'b0;
    check("b2b2_low", low, DW + 1);
    check("b2b2_q", sq(quotient), -15);
    check("b2b2_r", sr(remainder), 2);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      a = int'($signed(DW'($urandom)));
      b = int'($signed(VW'($urandom)));
`ifndef DIV_ZERO_DETECT_EN
      if (b == 0) b = 3;
`endif
      do_op(a, b, 1'b1, lat);
      check_res($sformatf("rnd%0d(%0d/%0d)", n, a, b), a, b, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
